ntt_core: RTL and testbench

NTT_CORE -- requirements
Module: ntt_core

---
 rtl/ntt_core.sv | 157 +++++++++++++++
 tb/tb_ntt_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core.sv
// ntt_core: in-place 256-point cyclic number-theoretic transform over Z_Q.
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst        asynchronous active-high reset; clears FSM, counters and memory
//   start      run request, accepted in IDLE or DONE
//   done       registered level, high once the memory holds the transform
//   ext_we     external write enable (honoured only in IDLE / DONE)
//   ext_addr   external write address and debug read address
//   ext_data   external write data, reduced once mod Q on the write edge
//   debug_out  combinational read of mem[ext_addr], valid in every state
//
// State     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for loads / start
// BF_READ   | latch A = mem[j], B = mem[j+len], Z = zeta[block]
// BF_MUL    | compute A' = A + Z*B, B' = A - Z*B (mod Q) into registers
// BF_WRITE  | write A' and B' back, step to next butterfly or finish
// DONE      | result in memory (bit-reversed order), loads / restart allowed
//
// Output stays in bit-reversed index order; there is no reorder pass.

module ntt_core #(
    parameter int DWIDTH = 12,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic              ext_we,
    input  logic [7:0]        ext_addr,
    input  logic [DWIDTH-1:0] ext_data,
    output logic [DWIDTH-1:0] debug_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BF_READ  = 3'd1,
        BF_MUL   = 3'd2,
        BF_WRITE = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef logic [127:0][DWIDTH-1:0] zrom_t;

    // Z[i] = 17^brv7(i) mod Q, built at elaboration time.
    function automatic zrom_t gen_zetas();
        zrom_t rom;
        zrom_t pw;
        int    r;
        pw[0] = DWIDTH'(1);
        for (int k = 1; k < 128; k++) begin
            pw[k] = DWIDTH'((int'(pw[k-1]) * 17) % Q);
        end
        for (int i = 0; i < 128; i++) begin
            r = 0;
            for (int bt = 0; bt < 7; bt++) begin
                if (((i >> bt) & 1) != 0) r = r | (1 << (6 - bt));
            end
            rom[i] = pw[r];
        end
        return rom;
    endfunction

    localparam zrom_t ZETA_ROM = gen_zetas();

    state_t            state_q;
    logic              done_q;
    logic [9:0]        k_q;        // butterfly index: [9:7] layer, [6:0] within layer
    logic [DWIDTH-1:0] a_q, b_q, z_q;
    logic [DWIDTH-1:0] ra_q, rb_q;
    logic [DWIDTH-1:0] mem_q [256];

    logic [2:0]        shamt;
    logic [6:0]        z_idx;
    logic [7:0]        mask8;
    logic [7:0]        a_addr, b_addr;
    logic [2*DWIDTH-1:0] prod, prod_red;
    logic [DWIDTH-1:0] t_mod;
    logic [DWIDTH:0]   sum, diff;
    logic [DWIDTH-1:0] ra_d, rb_d;
    logic [DWIDTH-1:0] ext_red;

    // Butterfly addressing: with len = 2^shamt, block b = m >> shamt and the
    // A index is m with a zero bit inserted at position shamt; B = A | len.
    always_comb begin
        shamt  = 3'd7 - k_q[9:7];
        z_idx  = k_q[6:0] >> shamt;
        mask8  = (8'd1 << shamt) - 8'd1;
        a_addr = (({1'b0, z_idx} << 1) << shamt) | ({1'b0, k_q[6:0]} & mask8);
        b_addr = a_addr | (8'd1 << shamt);
    end

    always_comb begin
        prod     = {{DWIDTH{1'b0}}, z_q} * {{DWIDTH{1'b0}}, b_q};
        prod_red = prod % (2*DWIDTH)'(Q);
        t_mod    = prod_red[DWIDTH-1:0];
        sum      = {1'b0, a_q} + {1'b0, t_mod};
        diff     = {1'b0, a_q} + ((DWIDTH+1)'(Q) - {1'b0, t_mod});
        ra_d     = (sum  >= (DWIDTH+1)'(Q)) ? DWIDTH'(sum  - (DWIDTH+1)'(Q)) : sum[DWIDTH-1:0];
        rb_d     = (diff >= (DWIDTH+1)'(Q)) ? DWIDTH'(diff - (DWIDTH+1)'(Q)) : diff[DWIDTH-1:0];
    end

    assign ext_red   = (ext_data >= DWIDTH'(Q)) ? ext_data - DWIDTH'(Q) : ext_data;
    assign debug_out = mem_q[ext_addr];
    assign done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            for (int i = 0; i < 256; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (ext_we) mem_q[ext_addr] <= ext_red;
                    if (start) begin
                        state_q <= BF_READ;
                        done_q  <= 1'b0;
                        k_q     <= '0;
                    end
                end
                BF_READ: begin
                    a_q     <= mem_q[a_addr];
                    b_q     <= mem_q[b_addr];
                    z_q     <= ZETA_ROM[z_idx];
                    state_q <= BF_MUL;
                end
                BF_MUL: begin
                    ra_q    <= ra_d;
                    rb_q    <= rb_d;
                    state_q <= BF_WRITE;
                end
                BF_WRITE: begin
                    mem_q[a_addr] <= ra_q;
                    mem_q[b_addr] <= rb_q;
                    if (k_q == 10'd1023) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        k_q     <= k_q + 10'd1;
                        state_q <= BF_READ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_core.sv
module tb_ntt_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic        ext_we = 1'b0;
    logic [7:0]  ext_addr = '0;
    logic [11:0] ext_data = '0;
    logic [11:0] debug_out;

    int checks = 0;
    int errors = 0;
    int ref_m [256];

    ntt_core #(.DWIDTH(12), .Q(3329)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .debug_out (debug_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int red(input int v);
        return (v >= 3329) ? v - 3329 : v;
    endfunction

    function automatic int zeta(input int i);
        int     r;
        longint p;
        r = 0;
        p = 1;
        for (int bt = 0; bt < 7; bt++) if (((i >> bt) & 1) != 0) r = r | (1 << (6 - bt));
        for (int k = 0; k < r; k++) p = (p * 17) % 3329;
        return int'(p);
    endfunction

    // Straightforward reference: layers, blocks, j, exactly as the transform is defined.
    task automatic ref_ntt();
        int len, z, t, a;
        len = 128;
        while (len >= 1) begin
            for (int b = 0; b < 128 / len; b++) begin
                z = zeta(b);
                for (int j = 2 * len * b; j < 2 * len * b + len; j++) begin
                    t = int'((longint'(z) * longint'(ref_m[j + len])) % 3329);
                    a = ref_m[j];
                    ref_m[j]       = (a + t) % 3329;
                    ref_m[j + len] = (a - t + 3329) % 3329;
                end
            end
            len = len / 2;
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) ref_m[i] = 0;
    endtask

    task automatic wr(input int addr, input int data);
        ext_we   = 1'b1;
        ext_addr = 8'(addr);
        ext_data = 12'(data);
        tick();
        ext_we   = 1'b0;
        ref_m[addr] = red(data);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++) begin
            ext_addr = 8'(i);
            #1;
            check(tag, 32'(debug_out), 32'(ref_m[i]));
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_done_async", 32'(done), 32'd0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        ref_clear();
    endtask

    // Pulses start (with whatever ext_we/addr/data the caller already set),
    // then measures edges until done. Optionally disturbs the run mid-way.
    task automatic run_and_time(input string tag, input bit disturb);
        int cyc;
        start = 1'b1;
        tick();
        start  = 1'b0;
        ext_we = 1'b0;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 4000) begin
            tick();
            cyc++;
            if (disturb) begin
                if (cyc >= 500 && cyc < 540) begin
                    ext_we   = 1'b1;
                    ext_addr = 8'(cyc);
                    ext_data = 12'(cyc + 1000);
                    start    = cyc[0];
                end else begin
                    ext_we = 1'b0;
                    start  = 1'b0;
                end
            end
        end
        ext_we = 1'b0;
        start  = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd3072);
    endtask

    initial begin
        int cyc;

        // Power-on reset
        #22;
        rst = 1'b0;
        tick();
        ref_clear();
        check("reset_done", 32'(done), 32'd0);
        check_mem("reset_mem");

        // Load reduction boundaries
        wr(5, 4095);
        wr(6, 3329);
        wr(7, 3328);
        ext_addr = 8'd5; #1; check("wr_4095", 32'(debug_out), 32'd766);
        ext_addr = 8'd6; #1; check("wr_3329", 32'(debug_out), 32'd0);
        ext_addr = 8'd7; #1; check("wr_3328", 32'(debug_out), 32'd3328);

        // Two-coefficient transform
        do_reset();
        check_mem("reset2_mem");
        wr(0, 100);
        wr(1, 50);
        ref_ntt();
        run_and_time("run_100_50", 1'b0);
        check("run1_done", 32'(done), 32'd1);
        ext_addr = 8'd0; #1; check("r1_addr0", 32'(debug_out), 32'd150);
        check("r1_addr0_changed", 32'(debug_out != 12'd100), 32'd1);
        ext_addr = 8'd1; #1; check("r1_addr1", 32'(debug_out), 32'd50);
        ext_addr = 8'd2; #1; check("r1_addr2", 32'(debug_out), 32'd3325);
        ext_addr = 8'd3; #1; check("r1_addr3", 32'(debug_out), 32'd204);
        check_mem("r1_mem");
        for (int i = 0; i < 5; i++) tick();
        check("done_holds", 32'(done), 32'd1);

        // Constant polynomial spreads to every point
        do_reset();
        wr(0, 7);
        run_and_time("run_const7", 1'b0);
        for (int i = 0; i < 256; i++) begin
            ext_addr = 8'(i);
            #1;
            check("const7_mem", 32'(debug_out), 32'd7);
        end

        // Full load from DONE; last write lands on the same edge as start
        for (int i = 0; i < 255; i++) wr(i, (i * 151 + 23) % 4096);
        ext_we   = 1'b1;
        ext_addr = 8'd255;
        ext_data = 12'd4000;
        ref_m[255] = red(4000);
        ref_ntt();
        run_and_time("run_full", 1'b0);
        check_mem("full_mem");

        // Run again on the result while hammering ext_we/start mid-run
        ref_ntt();
        run_and_time("run_disturb", 1'b1);
        check_mem("disturb_mem");

        // Reset at cycle 1000 of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (cyc < 1000) begin
            tick();
            cyc++;
        end
        #2;
        rst = 1'b1;
        #1;
        ref_clear();
        check("abort_done", 32'(done), 32'd0);
        check_mem("abort_mem");
        tick();
        #2;
        rst = 1'b0;
        wr(0, 9);
        wr(37, 3000);
        wr(200, 1234);
        ref_ntt();
        run_and_time("run_after_abort", 1'b0);
        check_mem("after_abort_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
